// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and counter-width helper
package audio_pkg;
    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] l;
        logic signed [SAMPLE_W-1:0] r;
    } sample_pair_t;

    function automatic int bit_cnt_w(input int slot_w);
        return $clog2(2 * slot_w);
    endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK divider with a fall-event strobe for the serializer
module i2s_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic fall_evt
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] dcnt;
    logic          wrap;

    assign wrap     = (dcnt == DW'(CLK_DIV - 1));
    // Strobe is true on the clk edge where bclk goes 1->0, so the parent advances on that same edge.
    assign fall_evt = wrap && bclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt <= '0;
            bclk <= 1'b0;
        end else if (wrap) begin
            dcnt <= '0;
            bclk <= ~bclk;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - Philips I2S stereo transmitter with one-deep holding register
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int SLOT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] sample_l,
    input  logic signed [SAMPLE_W-1:0] sample_r,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       bclk,
    output logic                       lrck,
    output logic                       sdata,
    output logic                       frame_start,
    output logic                       underrun
);
    localparam int CW         = bit_cnt_w(SLOT_W);
    localparam int FRAME_BITS = 2 * SLOT_W;

    logic                fall_evt;
    logic [CW-1:0]       b;
    logic [CW-1:0]       b_next;
    logic [CW-1:0]       k_pos;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] word_sh;
    logic                sdata_next;
    logic                accept;

    sample_pair_t        hold;
    logic                hold_full;
    logic [SAMPLE_W-1:0] l_shadow;
    logic [SAMPLE_W-1:0] r_pend;
    logic [SAMPLE_W-1:0] r_shadow;

    i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    assign sample_ready = !hold_full && enable;
    assign accept       = sample_valid && sample_ready;
    assign b_next       = (b == CW'(FRAME_BITS - 1)) ? '0 : b + 1'b1;

    // The bit driven on this fall belongs to the old b, giving the one-BCLK Philips delay.
    // Shifting left by k also zeroes the padding bits beyond the 16th.
    always_comb begin
        word       = '0;
        k_pos      = '0;
        word_sh    = '0;
        sdata_next = 1'b0;
        if (b < CW'(SLOT_W)) begin
            word  = l_shadow;
            k_pos = b;
        end else begin
            word  = r_shadow;
            k_pos = b - CW'(SLOT_W);
        end
        word_sh    = word << k_pos;
        sdata_next = word_sh[SAMPLE_W-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b           <= CW'(FRAME_BITS - 1);
            lrck        <= 1'b1;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            l_shadow    <= '0;
            r_pend      <= '0;
            r_shadow    <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (accept) begin
                hold.l    <= sample_l;
                hold.r    <= sample_r;
                hold_full <= 1'b1;
            end
            if (fall_evt) begin
                b     <= b_next;
                lrck  <= (b_next >= CW'(SLOT_W));
                sdata <= sdata_next;
                if (b_next == '0) begin
                    frame_start <= 1'b1;
                    if (enable && hold_full) begin
                        l_shadow  <= hold.l;
                        r_pend    <= hold.r;
                        hold_full <= 1'b0;
                    end else begin
                        l_shadow <= '0;
                        r_pend   <= '0;
                        underrun <= enable;
                    end
                end
                // Right word is latched mid-frame so its LSB survives the next frame load.
                if (b_next == CW'(SLOT_W)) begin
                    r_shadow <= r_pend;
                end
            end
        end
    end
endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Stereo I2S (Philips format) transmitter that sits directly downstream of the compressor. It accepts 16-bit signed sample pairs through a one-deep valid/ready holding register and generates BCLK and LRCK as clock-enabled registered outputs. It serializes each frame MSB-first to the audio DAC. On underrun the frame is muted rather than stalled, so the DAC always sees continuous clocks.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per BCLK half-period; must be ≥1.
- SLOT_W, 16: BCLK periods per channel slot; must be ≥16. Bits past the 16th are 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = transmit accepted samples; 0 = mute (frames carry zeros, no samples consumed)
- sample_l  in  16  signed left sample (compressor output)
- sample_r  in  16  signed right sample
- sample_valid  in  1  sample pair present
- sample_ready  out  1  holding register empty and enable=1; a transfer occurs when valid&&ready at a clk edge
- bclk  out  1  bit clock, registered
- lrck  out  1  word select, registered; 0 = left, 1 = right
- sdata  out  1  serial data, registered; changes only with BCLK falling
- frame_start  out  1  one-clk pulse on the fall event that begins a frame
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty while enable=1

## Operation
- Divider counter dcnt cycles 0..CLK_DIV-1. When dcnt==CLK_DIV-1, bclk toggles and dcnt returns to 0. A 1→0 toggle is a "fall event"; all other state advances only on fall events.
- Bit counter b runs 0..2*SLOT_W-1 and increments mod 2*SLOT_W on each fall event.
- On a fall event, with b the new value:
  - lrck ← (b ≥ SLOT_W).
  - Output position d = (b-1) mod 2*SLOT_W; k = d mod SLOT_W.
  - Word = L_shadow if d < SLOT_W, else R_shadow.
  - sdata ← word[15-k] if k < 16, else 0.
  - This yields the one-BCLK Philips delay: the MSB follows each lrck edge.
- Frame load at fall event b==0:
  - If enable && hold_full: L_shadow ← hold_L, R_pend ← hold_R, and hold_full clears.
  - Otherwise: L_shadow ← 0, R_pend ← 0, underrun pulses if enable, and hold_full is unchanged.
  - frame_start pulses in both cases.
- R_shadow ← R_pend at fall event b==SLOT_W. R_shadow must persist through b==0 of the next frame, because that event outputs the right-channel LSB position.
- Holding register: when valid&&ready, hold_L/hold_R ← inputs and hold_full sets. sample_ready = !hold_full && enable (combinational from registers).
- Simultaneous events:
  - Frame load at b==0 with hold_full=0 and valid&&ready in the same cycle: underrun fires, the new pair is accepted into holding, and it transmits next frame.
  - hold_full=1 at the b==0 load: ready=0 that cycle; ready rises the following clk.
- enable deasserted: bclk/lrck keep running; the held sample is retained; frames are muted with no underrun pulse.

## Timing
- Reset values: dcnt=0, bclk=0, b=2*SLOT_W-1, lrck=1, sdata=0, shadows/pend/hold=0, hold_full=0, frame_start=0, underrun=0.
- After reset release, the first bclk rise occurs at clk edge CLK_DIV. The first fall event (b==0, lrck→0, frame_start) occurs at edge 2*CLK_DIV.
- Frame period = 4*CLK_DIV*SLOT_W clk cycles.
- Latency from an accepted pair to its left MSB on sdata: MSB appears at the fall event b==1 of the next frame start.
- Asynchronous reset mid-frame returns every register to its reset value immediately. The partial frame is discarded and no pulse is emitted.

## Structure
- Shared package audio_pkg: SAMPLE_W=16 and a localparam helper for the counter width, clog2(2*SLOT_W).
- Sub-module i2s_clk_gen holds dcnt, bclk and the fall-event strobe.
- The parent holds b, lrck, sdata, the holding register, the shadows and the handshake logic.

## Test plan
All scenarios use CLK_DIV=2, SLOT_W=16 (128-clk frame).
- Reset check: hold reset_n=0 -> every output at its reset value. After release, first bclk rise at edge 2, first frame_start at edge 4 with lrck→0.
- Single pair: L=16'h8001, R=16'h7FFE pushed before frame 1 -> on BCLK rising edges, left bits 1,0×14,1 and right bits 0,1×14,0. MSB is one BCLK after each lrck edge.
- Underrun: no sample offered -> underrun pulses at every frame_start and sdata stays 0. Then push 16'h1234/16'h5678 -> the next frame carries it.
- Back-pressure: valid held high with two pairs queued -> ready drops after the first transfer and rises one clk after frame_start. Pairs appear in order in consecutive frames.
- Simultaneous load and accept: assert valid in the exact cycle of the b==0 load with holding empty -> underrun pulses, the pair is accepted, and it transmits in the next frame.
- Enable/mute and mid-frame reset: enable=0 with hold full -> zero frames, no underrun, ready=0; enable=1 -> the held pair transmits. Reset at b==20 -> outputs return to reset values within the same cycle.
